// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory controller slice.
//
// Contents:
//   stateT           controller FSM states (IDLE, REQ, RESP, DONE)
//   SZ_BYTE/HALF/WORD  encodings of the core's mem_sizeM field (11 acts as word)
//   DEFAULT_TIMEOUT  default bus wait limit in cycles
//   isMisaligned()   alignment test used when DMEM_MISALIGN_CHK_EN is defined
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } stateT;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  // A halfword must sit on an even address and a word on a multiple of four.
  // Size 11 is a word, so anything that is not byte or half is held to the
  // word rule.
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane -- byte-lane steering between the core and a 32-bit bus.
//
// Purely combinational.
// Ports:
//   size         access size (SZ_BYTE / SZ_HALF / SZ_WORD, 11 = word)
//   addrLo       low two address bits of the access
//   wd           store data from the core, LSB-justified
//   rdata        raw word returned by the bus
//   be           byte enables for the bus
//   wdata        store data replicated onto every lane it could occupy
//   rdataShifted read word shifted so the addressed data is LSB-justified
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdataShifted
);

  // Store data is replicated across all lanes so the bus slave can pick it up
  // from whichever lane the byte enables select. A halfword only looks at
  // addr[1] and a word ignores the low bits entirely, so unaligned halves and
  // words quietly land on the enclosing aligned slot. The read data shift
  // follows the same rule so loads and stores agree on which lanes they use.
  always_comb begin
    be           = 4'b1111;
    wdata        = wd;
    rdataShifted = rdata;
    case (size)
      SZ_BYTE: begin
        be           = 4'b0001 << addrLo;
        wdata        = {4{wd[7:0]}};
        rdataShifted = rdata >> {addrLo, 3'b000};
      end
      SZ_HALF: begin
        be           = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata        = {2{wd[15:0]}};
        rdataShifted = addrLo[1] ? (rdata >> 16) : rdata;
      end
      default: begin
        be           = 4'b1111;
        wdata        = wd;
        rdataShifted = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- M-stage data-memory controller bridging the core to a
// valid/ready request bus with a separate read-response channel.
//
// Optional feature: define DMEM_MISALIGN_CHK_EN to reject misaligned halfword
// and word accesses with an error instead of issuing them on the bus.
//
// Parameter:
//   TIMEOUT_CYCLES  bus wait limit, counted over REQ and RESP together
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   memreadM        load request from the core
//   memwriteM       store request from the core (wins if both are high)
//   mem_sizeM       00 byte, 01 half, 10/11 word
//   aluoutM         byte address
//   writedataM      store data, LSB-justified
//   readdataM       registered load data, LSB-justified, not extended
//   stallM          freezes the core pipeline while an access is in flight
//   memerrM         one-cycle error pulse (bus error, timeout, misalignment)
//   bus_valid/bus_we/bus_addr/bus_be/bus_wdata   request channel
//   bus_ready       slave accepted the request
//   bus_rvalid/bus_rdata  read response
//   bus_err         error flag qualified by bus_ready (store) or bus_rvalid (load)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  mem_sizeM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        memerrM,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  stateT       state;
  stateT       nextState;
  logic [31:0] addrQ;
  logic [1:0]  sizeQ;
  logic [31:0] wdQ;
  logic        weQ;
  logic        errQ;
  logic [CNT_W-1:0] cnt;

  logic        latchReq;
  logic        abort;
  logic        clearRd;
  logic        captureRd;
  logic        timeoutHit;

  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [31:0] laneRdata;

  dmem_lane lane (
    .size         (sizeQ),
    .addrLo       (addrQ[1:0]),
    .wd           (wdQ),
    .rdata        (bus_rdata),
    .be           (laneBe),
    .wdata        (laneWdata),
    .rdataShifted (laneRdata)
  );

  // cnt holds the number of REQ/RESP cycles already spent, so when it shows
  // TIMEOUT_CYCLES-1 the current cycle is the last one the slave gets.
  assign timeoutHit = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and output decode. The bus request fields are driven only in
  // REQ and are zero otherwise, so reset or an abort drops the whole request
  // at once. A store whose ready carries bus_err, a load whose rvalid carries
  // bus_err, and a timeout all finish through DONE with the error flag set;
  // only failed loads clear readdataM, so a failed store leaves the last load
  // value intact. DONE never looks at the core request, which keeps a request
  // still held during DONE from being issued a second time.
  always_comb begin
    nextState = state;
    stallM    = 1'b0;
    memerrM   = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    latchReq  = 1'b0;
    abort     = 1'b0;
    clearRd   = 1'b0;
    captureRd = 1'b0;
    case (state)
      IDLE: begin
        if (memreadM || memwriteM) begin
          stallM   = 1'b1;
          latchReq = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
          if (isMisaligned(mem_sizeM, aluoutM[1:0])) begin
            nextState = DONE;
            abort     = 1'b1;
            clearRd   = !memwriteM;
          end else begin
            nextState = REQ;
          end
`else
          nextState = REQ;
`endif
        end
      end
      REQ: begin
        stallM    = 1'b1;
        bus_valid = 1'b1;
        bus_we    = weQ;
        bus_addr  = {addrQ[31:2], 2'b00};
        bus_be    = laneBe;
        bus_wdata = laneWdata;
        if (bus_ready) begin
          if (weQ) begin
            nextState = DONE;
            abort     = bus_err;
          end else begin
            nextState = RESP;
          end
        end else if (timeoutHit) begin
          nextState = DONE;
          abort     = 1'b1;
          clearRd   = !weQ;
        end
      end
      RESP: begin
        stallM = 1'b1;
        if (bus_rvalid) begin
          nextState = DONE;
          if (bus_err) begin
            abort   = 1'b1;
            clearRd = 1'b1;
          end else begin
            captureRd = 1'b1;
          end
        end else if (timeoutHit) begin
          nextState = DONE;
          abort     = 1'b1;
          clearRd   = 1'b1;
        end
      end
      default: begin
        memerrM   = errQ;
        nextState = IDLE;
      end
    endcase
  end

  // State register and datapath. The request is captured while IDLE accepts
  // it so the bus sees stable values for the whole REQ phase. errQ simply
  // follows abort: it is set on the edge into DONE and drops on the edge out,
  // which makes memerrM a single-cycle pulse. The wait counter restarts
  // whenever the FSM is not staying inside REQ/RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      sizeQ     <= SZ_BYTE;
      wdQ       <= '0;
      weQ       <= 1'b0;
      errQ      <= 1'b0;
      cnt       <= '0;
      readdataM <= '0;
    end else begin
      state <= nextState;
      errQ  <= abort;
      if (latchReq) begin
        addrQ <= aluoutM;
        sizeQ <= mem_sizeM;
        wdQ   <= writedataM;
        weQ   <= memwriteM;
      end
      if (captureRd) begin
        readdataM <= laneRdata;
      end else if (clearRd) begin
        readdataM <= '0;
      end
      if ((state == REQ || state == RESP) &&
          (nextState == REQ || nextState == RESP)) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- self-checking bench for dmem_ctrl.
//
// Stimulus plays both the core (request held until stallM drops) and the bus
// slave (programmable ready/rvalid delays, errors, silent slave). Each access
// pushes its expected outcome, computed from the access rules, into a queue;
// a monitor on the falling edge counts stall cycles and bus handshakes and
// checks the front of the queue whenever an access finishes (stallM falls).
// Honours DMEM_MISALIGN_CHK_EN the same way the design does.
module tb_dmem_ctrl;

  localparam int TMO = 8;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          readyDelay;
    int          rvDelay;
    bit          err;
    bit          noReady;
    bit          noRvalid;
  } txnT;

  typedef struct {
    bit          err;
    int          stall;
    int          busCount;
    bit          isStore;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] rd;
    bit          checkRd;
  } expT;

  logic        clk;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic [1:0]  mem_sizeM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        memerrM;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int  checks = 0;
  int  errors = 0;
  expT expQ[$];

  int          stallCount = 0;
  int          busCount = 0;
  logic [3:0]  obsBe;
  logic [31:0] obsWdata;
  logic [31:0] obsAddr;
  logic        obsWe;

  dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .mem_sizeM  (mem_sizeM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .memerrM    (memerrM),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_err    (bus_err),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one access from the size/lane rules, the
  // error rules and the cycle budget (1 IDLE cycle, then REQ and RESP waits).
  function automatic expT model(input txnT t);
    expT        e;
    int         a;
    int         shift;
    logic [1:0] sz;
    e       = '{default: 0};
    a       = int'(t.addr[1:0]);
    sz      = (t.size == 2'b11) ? 2'b10 : t.size;
    e.isStore = t.wr;
    e.addr  = t.addr & 32'hFFFF_FFFC;
    if (sz == 2'b00) begin
      e.be    = 4'(1 << a);
      e.wdata = {24'h0, t.wd[7:0]} * 32'h0101_0101;
      shift   = 8 * a;
    end else if (sz == 2'b01) begin
      e.be    = 4'(3 << (2 * (a / 2)));
      e.wdata = {16'h0, t.wd[15:0]} * 32'h0001_0001;
      shift   = 16 * (a / 2);
    end else begin
      e.be    = 4'hF;
      e.wdata = t.wd;
      shift   = 0;
    end
    e.checkRd = !e.isStore;
`ifdef DMEM_MISALIGN_CHK_EN
    if ((sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && a != 0)) begin
      e.err = 1; e.stall = 1; e.busCount = 0; e.rd = 0;
      return e;
    end
`endif
    if (t.noReady) begin
      e.err = 1; e.stall = 1 + TMO; e.busCount = 0; e.rd = 0;
    end else if (e.isStore) begin
      e.err = t.err; e.stall = 2 + t.readyDelay; e.busCount = 1;
    end else if (t.noRvalid) begin
      e.err = 1; e.stall = 1 + TMO; e.busCount = 1; e.rd = 0;
    end else begin
      e.err = t.err; e.stall = 3 + t.readyDelay + t.rvDelay; e.busCount = 1;
      e.rd = t.err ? 32'h0 : (t.rdata >> shift);
    end
    return e;
  endfunction

  function automatic txnT mk(input logic rd, input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int rdyD, input int rvD);
    txnT t;
    t = '{default: 0};
    t.rd = rd; t.wr = wr; t.size = size; t.addr = addr; t.wd = wd;
    t.rdata = rdata; t.readyDelay = rdyD; t.rvDelay = rvD;
    return t;
  endfunction

  function automatic txnT randTxn();
    txnT t;
    int  kind;
    kind = $urandom_range(0, 5);
    t = mk(kind <= 2 || kind == 5, kind >= 3, 2'($urandom_range(0, 3)), $urandom,
           $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    t.err      = ($urandom_range(0, 7) == 0);
    t.noReady  = ($urandom_range(0, 15) == 0);
    t.noRvalid = !t.wr && ($urandom_range(0, 15) == 0);
    return t;
  endfunction

  // Core + slave driver. Inputs change 1ns after the rising edge. Returns in
  // the DONE cycle with the request still held, like a core that only moves
  // on at the next edge.
  task automatic applyStimulus(input txnT t);
    int phase;
    int waitCnt;
    int cycles;
    expQ.push_back(model(t));
    @(posedge clk); #1;
    memreadM = t.rd; memwriteM = t.wr; mem_sizeM = t.size;
    aluoutM = t.addr; writedataM = t.wd;
    phase = 0; waitCnt = 0; cycles = 0;
    forever begin
      @(posedge clk); #1;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (!stallM) break;
      cycles++;
      if (cycles > 64) begin
        checks++; errors++;
        $display("[TB] FAIL hang: access still stalled after %0d cycles", cycles);
        finishRun();
      end
      if (phase == 0 && bus_valid) begin
        if (!t.noReady && waitCnt == t.readyDelay) begin
          bus_ready = 1'b1;
          if (t.wr) bus_err = t.err;
          phase = t.wr ? 2 : 1;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (phase == 1) begin
        if (!t.noRvalid && waitCnt == t.rvDelay) begin
          bus_rvalid = 1'b1; bus_rdata = t.rdata; bus_err = t.err;
          phase = 2;
        end else begin
          waitCnt++;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      memreadM = 1'b0; memwriteM = 1'b0;
    end
  endtask

  // Monitor: counts stall cycles and bus handshakes, and scores each access
  // against the queue when stallM falls.
  always @(negedge clk) begin
    if (!reset) begin
      stallCount = 0;
      busCount = 0;
    end else begin
      if (bus_valid && bus_ready) begin
        busCount++;
        obsBe = bus_be; obsWdata = bus_wdata; obsAddr = bus_addr; obsWe = bus_we;
      end
      if (stallM) begin
        stallCount++;
      end else if (stallCount > 0) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected: access finished with nothing expected");
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("memerrM", 32'(memerrM), 32'(e.err));
          checkOutput("stallCycles", 32'(stallCount), 32'(e.stall));
          checkOutput("busTransactions", 32'(busCount), 32'(e.busCount));
          checkOutput("busValidInDone", 32'(bus_valid), 32'h0);
          if (e.busCount > 0) begin
            checkOutput("bus_be", 32'(obsBe), 32'(e.be));
            checkOutput("bus_addr", obsAddr, e.addr);
            checkOutput("bus_we", 32'(obsWe), 32'(e.isStore));
            if (e.isStore) checkOutput("bus_wdata", obsWdata, e.wdata);
          end
          if (e.checkRd) checkOutput("readdataM", readdataM, e.rd);
        end
        stallCount = 0;
        busCount = 0;
      end
    end
  end

  initial begin
    #200000;
    checks++; errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishRun();
  end

  initial begin
    txnT t;
    reset = 1'b0; memreadM = 1'b0; memwriteM = 1'b0; mem_sizeM = 2'b00;
    aluoutM = '0; writedataM = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReaddataM", readdataM, 32'h0);
    checkOutput("resetStallM", 32'(stallM), 32'h0);
    checkOutput("resetMemerrM", 32'(memerrM), 32'h0);
    checkOutput("resetBusValid", 32'(bus_valid), 32'h0);
    checkOutput("resetBusWe", 32'(bus_we), 32'h0);
    checkOutput("resetBusBe", 32'(bus_be), 32'h0);
    checkOutput("resetBusAddr", bus_addr, 32'h0);
    checkOutput("resetBusWdata", bus_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] sb 0x103 with immediate ready");
    applyStimulus(mk(0, 1, 2'b00, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0, 0));
    idleCycles(1);

    $display("[TB] lh 0x102 with rvalid three cycles late");
    applyStimulus(mk(1, 0, 2'b01, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 3));
    idleCycles(1);

    $display("[TB] lw with a silent slave times out");
    t = mk(1, 0, 2'b10, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    t.noReady = 1;
    applyStimulus(t);
    idleCycles(1);

    applyStimulus(mk(1, 0, 2'b10, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 1));

    $display("[TB] reset while waiting for read data");
    @(posedge clk); #1;
    memreadM = 1'b1; memwriteM = 1'b0; mem_sizeM = 2'b10; aluoutM = 32'h0000_0300;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0; reset = 1'b0; memreadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("afterResetStallM", 32'(stallM), 32'h0);
    checkOutput("afterResetBusValid", 32'(bus_valid), 32'h0);
    checkOutput("afterResetReaddataM", readdataM, 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("lateRvalidReaddataM", readdataM, 32'h0);
    checkOutput("lateRvalidMemerrM", 32'(memerrM), 32'h0);

    $display("[TB] back-to-back sw then lw");
    applyStimulus(mk(0, 1, 2'b10, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 0, 0));
    applyStimulus(mk(1, 0, 2'b10, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0, 0));

    $display("[TB] both strobes high, size 11, and error cases");
    applyStimulus(mk(1, 1, 2'b11, 32'h0000_0502, 32'h8765_4321, 32'h0, 2, 0));
    t = mk(0, 1, 2'b01, 32'h0000_0602, 32'h0000_5A5A, 32'h0, 1, 0);
    t.err = 1;
    applyStimulus(t);
    applyStimulus(mk(1, 0, 2'b00, 32'h0000_0701, 32'h0, 32'h00C3_0000, 0, 2));
    t = mk(1, 0, 2'b00, 32'h0000_0702, 32'h0, 32'h1111_1111, 0, 1);
    t.err = 1;
    applyStimulus(t);
    t = mk(1, 0, 2'b10, 32'h0000_0800, 32'h0, 32'h0, 0, 0);
    t.noRvalid = 1;
    applyStimulus(t);

`ifdef DMEM_MISALIGN_CHK_EN
    $display("[TB] misaligned lw 0x101 is rejected");
    applyStimulus(mk(1, 0, 2'b10, 32'h0000_0101, 32'h0, 32'h0, 0, 0));
`endif

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(randTxn());
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end

    idleCycles(4);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);
    finishRun();
  end

endmodule
